// File: rtl/mips_defs.sv
// Shared MIPS decode constants for the W stage.
// Holds the opcode and funct field values the writeback decoder needs, the
// return-address register number, and the writeback-source select encoding.
package mips_defs;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_IALU_LO = 6'h08;  // addi .. lui occupy 0x08-0x0f
    localparam logic [5:0] OP_IALU_HI = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    localparam logic [4:0] REG_RA = 5'd31;

    // Writeback data source
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC8 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/load_ext.sv
// Load data extender.
// Picks the byte or halfword addressed by addr out of the little-endian memory
// word DR_W and sign- or zero-extends it according to the load opcode.
// Ports:
//   addr    in  2   byte offset within the word (bit 0 ignored for halfwords)
//   op      in  6   W-stage opcode
//   DR_W    in  32  raw word from data memory
//   ld_data out 32  extended load value (DR_W unchanged for lw / non-loads)
module load_ext
    import mips_defs::*;
(
    input  logic [1:0]  addr,
    input  logic [5:0]  op,
    input  logic [31:0] DR_W,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        byte_sel = DR_W[7:0];
        case (addr)
            2'd0: byte_sel = DR_W[7:0];
            2'd1: byte_sel = DR_W[15:8];
            2'd2: byte_sel = DR_W[23:16];
            2'd3: byte_sel = DR_W[31:24];
            default: byte_sel = DR_W[7:0];
        endcase
        half_sel = addr[1] ? DR_W[31:16] : DR_W[15:0];
    end

    always_comb begin
        ld_data = DR_W;
        case (op)
            OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_data = {24'd0, byte_sel};
            OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_data = {16'd0, half_sel};
            default: ld_data = DR_W;
        endcase
    end

endmodule

// File: rtl/w_writeback_grf.sv
// W-stage writeback and general register file.
// Decodes the W-stage instruction, selects the writeback value (ALU result,
// extended load data or PC+8), writes the GRF, serves two D-stage read ports
// with same-cycle bypass of the value being written, and registers a commit
// record of each nonzero-register write.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   IR_W, AO_W, DR_W  W-stage instruction, ALU result / address, memory word
//   WPC_W, PC4_W      W-stage PC and PC+4
//   A1/A2 -> RD1/RD2  combinational read ports (bypass from W_A3/W_WD)
//   W_A3, W_WD        destination register (0 = none) and writeback data
//   commit_*          registered record of last cycle's write
module w_writeback_grf
    import mips_defs::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   IR_W,
    input  logic [DW-1:0] AO_W,
    input  logic [DW-1:0] DR_W,
    input  logic [31:0]   WPC_W,
    input  logic [31:0]   PC4_W,
    input  logic [4:0]    A1,
    input  logic [4:0]    A2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic [4:0]    W_A3,
    output logic [DW-1:0] W_WD,
    output logic          commit_valid,
    output logic [31:0]   commit_pc,
    output logic [4:0]    commit_addr,
    output logic [DW-1:0] commit_data
);

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [4:0]    rt;
    logic [4:0]    rd;
    wb_sel_e       wb_sel;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] grf [NREG];

    assign op    = IR_W[31:26];
    assign funct = IR_W[5:0];
    assign rt    = IR_W[20:16];
    assign rd    = IR_W[15:11];

    // rs and shamt play no part in writeback.
    logic unused_fields;
    assign unused_fields = ^{IR_W[25:21], IR_W[10:6]};

    // Destination and source decode
    always_comb begin
        W_A3   = 5'd0;
        wb_sel = WB_ALU;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_JR, FN_MTHI, FN_MTLO,
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: W_A3 = 5'd0;
                    FN_JALR: begin
                        W_A3   = rd;
                        wb_sel = WB_PC8;
                    end
                    default: W_A3 = rd;
                endcase
            end
            OP_JAL: begin
                W_A3   = REG_RA;
                wb_sel = WB_PC8;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                W_A3   = rt;
                wb_sel = WB_MEM;
            end
            default: begin
                if (op >= OP_IALU_LO && op <= OP_IALU_HI) W_A3 = rt;
            end
        endcase
    end

    load_ext u_load_ext (
        .addr    (AO_W[1:0]),
        .op      (op),
        .DR_W    (DR_W),
        .ld_data (ld_data)
    );

    // A nop decodes as sll $0; force its data to zero so the forwarding unit
    // sees a clean value rather than whatever sits on AO_W.
    always_comb begin
        W_WD = AO_W;
        if (IR_W != 32'd0) begin
            case (wb_sel)
                WB_PC8:  W_WD = PC4_W + 32'd4;
                WB_MEM:  W_WD = ld_data;
                default: W_WD = AO_W;
            endcase
        end else begin
            W_WD = '0;
        end
    end

    // Register file write and commit record
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the GRF architecturally starts at zero, so the array is
            // cleared here; this prevents mapping it to a RAM macro, which is
            // acceptable for 32 entries.
            for (int i = 0; i < NREG; i++) grf[i] <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_addr  <= '0;
            commit_data  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // read in this block sees the pre-edge value.
            if (W_A3 != 5'd0) begin
                grf[W_A3]    <= W_WD;
                commit_valid <= 1'b1;
                commit_pc    <= WPC_W;
                commit_addr  <= W_A3;
                commit_data  <= W_WD;
            end else begin
                commit_valid <= 1'b0;
            end
        end
    end

    // Read ports with bypass of the in-flight write
    always_comb begin
        RD1 = grf[A1];
        RD2 = grf[A2];
        if (A1 == 5'd0)       RD1 = '0;
        else if (A1 == W_A3)  RD1 = W_WD;
        if (A2 == 5'd0)       RD2 = '0;
        else if (A2 == W_A3)  RD2 = W_WD;
    end

endmodule

// File: tb/tb_w_writeback_grf.sv
// Self-checking bench for w_writeback_grf: a reference model of the register
// file and commit record is compared against the DUT on every falling edge,
// and directed literal checks pin the model on the key scenarios.
module tb_w_writeback_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_W, AO_W, DR_W, WPC_W, PC4_W;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, W_WD, commit_pc, commit_data;
    logic [4:0]  W_A3, commit_addr;
    logic        commit_valid;

    int n_cmp = 0;
    int n_err = 0;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    w_writeback_grf #(.NREG(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .IR_W         (IR_W),
        .AO_W         (AO_W),
        .DR_W         (DR_W),
        .WPC_W        (WPC_W),
        .PC4_W        (PC4_W),
        .A1           (A1),
        .A2           (A2),
        .RD1          (RD1),
        .RD2          (RD2),
        .W_A3         (W_A3),
        .W_WD         (W_WD),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [4:0] ref_dest(input logic [31:0] ir);
        int op = int'(ir[31:26]);
        int fn = int'(ir[5:0]);
        if (op == 0) begin
            if (fn == 'h08 || fn == 'h11 || fn == 'h13 || (fn >= 'h18 && fn <= 'h1b)) return 5'd0;
            return ir[15:11];
        end
        if (op == 'h03) return 5'd31;
        if (op == 'h20 || op == 'h21 || op == 'h23 || op == 'h24 || op == 'h25) return ir[20:16];
        if (op >= 'h08 && op <= 'h0f) return ir[20:16];
        return 5'd0;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [31:0] ir, input logic [31:0] ao,
                                           input logic [31:0] dr, input logic [31:0] pc4);
        int op = int'(ir[31:26]);
        logic [31:0] b, h;
        if (ir == 32'd0) return 32'd0;
        if (op == 'h03 || (op == 0 && ir[5:0] == 6'h09)) return pc4 + 32'd4;
        b = (dr >> (8 * ao[1:0])) & 32'hFF;
        h = (dr >> (16 * ao[1])) & 32'hFFFF;
        case (op)
            'h20: return (b >= 32'h80) ? b - 32'h100 : b;
            'h24: return b;
            'h21: return (h >= 32'h8000) ? h - 32'h10000 : h;
            'h25: return h;
            'h23: return dr;
            default: return ao;
        endcase
    endfunction

    logic [31:0] mgrf [32];
    logic        m_cv;
    logic [31:0] m_cpc, m_cdata;
    logic [4:0]  m_caddr;

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        logic [4:0] d = ref_dest(IR_W);
        if (a == 5'd0) return 32'd0;
        if (a == d) return ref_wd(IR_W, AO_W, DR_W, PC4_W);
        return mgrf[a];
    endfunction

    always @(posedge clk) begin
        logic [4:0]  d;
        logic [31:0] wd;
        d  = ref_dest(IR_W);
        wd = ref_wd(IR_W, AO_W, DR_W, PC4_W);
        if (reset) begin
            for (int i = 0; i < 32; i++) mgrf[i] <= 32'd0;
            m_cv <= 1'b0; m_cpc <= 32'd0; m_caddr <= 5'd0; m_cdata <= 32'd0;
        end else if (d != 5'd0) begin
            mgrf[d] <= wd;
            m_cv <= 1'b1; m_cpc <= WPC_W; m_caddr <= d; m_cdata <= wd;
        end else begin
            m_cv <= 1'b0;
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (checking) begin
            check("W_A3", {27'd0, W_A3}, {27'd0, ref_dest(IR_W)});
            check("W_WD", W_WD, ref_wd(IR_W, AO_W, DR_W, PC4_W));
            check("RD1", RD1, ref_rd(A1));
            check("RD2", RD2, ref_rd(A2));
            check("commit_valid", {31'd0, commit_valid}, {31'd0, m_cv});
            check("commit_pc", commit_pc, m_cpc);
            check("commit_addr", {27'd0, commit_addr}, {27'd0, m_caddr});
            check("commit_data", commit_data, m_cdata);
        end
    end

    // Drive one cycle of inputs just after the rising edge, return at the
    // following falling edge so literal checks see settled outputs.
    task automatic step(input logic rst, input logic [31:0] ir, input logic [31:0] ao,
                        input logic [31:0] dr, input logic [31:0] wpc,
                        input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        reset = rst; IR_W = ir; AO_W = ao; DR_W = dr; WPC_W = wpc; PC4_W = wpc + 32'd4;
        A1 = a1; A2 = a2;
        @(negedge clk);
    endtask

    localparam logic [31:0] LDW = 32'h80FF7F01;
    logic [31:0] lb_exp [4];

    initial begin
        reset = 1'b1; IR_W = '0; AO_W = '0; DR_W = '0; WPC_W = '0; PC4_W = 32'd4;
        A1 = '0; A2 = '0;
        lb_exp[0] = 32'h00000001; lb_exp[1] = 32'h0000007F;
        lb_exp[2] = 32'hFFFFFFFF; lb_exp[3] = 32'hFFFFFF80;
        repeat (2) @(posedge clk);
        #1 checking = 1'b1;

        // 1: preload via ori, then reset and sweep both ports
        reset = 1'b0;
        for (int r = 1; r < 8; r++)
            step(1'b0, itype(6'h0d, 5'd0, 5'(r), 16'(r * 16'h111)), 32'(r * 32'h111), 32'd0,
                 32'h1000 + 32'(4 * r), 5'd0, 5'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd3, 5'd7);
        check("preload_rd1", RD1, 32'h00000333);
        step(1'b1, 32'd0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'(a), 5'(31 - a));
            check("reset_rd1", RD1, 32'd0);
            check("reset_rd2", RD2, 32'd0);
        end
        check("reset_cv", {31'd0, commit_valid}, 32'd0);

        // 2: ori $5 with bypass, then array read and commit record
        step(1'b0, itype(6'h0d, 5'd0, 5'd5, 16'h1234), 32'h00001234, 32'd0, 32'h2000, 5'd5, 5'd5);
        check("bypass_rd1", RD1, 32'h00001234);
        check("bypass_rd2", RD2, 32'h00001234);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h2004, 5'd5, 5'd0);
        check("array_rd1", RD1, 32'h00001234);
        check("ori_cv", {31'd0, commit_valid}, 32'd1);
        check("ori_caddr", {27'd0, commit_addr}, 32'd5);
        check("ori_cdata", commit_data, 32'h00001234);
        check("ori_cpc", commit_pc, 32'h2000);
        check("nop_wa3", {27'd0, W_A3}, 32'd0);
        check("nop_wwd", W_WD, 32'd0);

        // 3: lb at each byte offset
        for (int off = 0; off < 4; off++) begin
            step(1'b0, itype(6'h20, 5'd4, 5'd7, 16'(off)), 32'h100 + 32'(off), LDW,
                 32'h3000, 5'd7, 5'd0);
            check("lb_bypass", RD1, lb_exp[off]);
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd7, 5'd0);
            check("lb_array", RD1, lb_exp[off]);
        end

        // 4: lbu / lh / lhu
        step(1'b0, itype(6'h24, 5'd4, 5'd7, 16'd3), 32'h103, LDW, 32'h3010, 5'd0, 5'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd7, 5'd0);
        check("lbu_off3", RD1, 32'h00000080);
        step(1'b0, itype(6'h21, 5'd4, 5'd8, 16'd2), 32'h102, LDW, 32'h3014, 5'd0, 5'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd8, 5'd0);
        check("lh_hi", RD1, 32'hFFFF80FF);
        step(1'b0, itype(6'h25, 5'd4, 5'd8, 16'd3), 32'h103, LDW, 32'h3018, 5'd0, 5'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd8, 5'd0);
        check("lhu_hi", RD1, 32'h000080FF);
        step(1'b0, itype(6'h21, 5'd4, 5'd8, 16'd0), 32'h100, LDW, 32'h301c, 5'd8, 5'd0);
        check("lh_lo", RD1, 32'h00007F01);
        step(1'b0, itype(6'h23, 5'd4, 5'd8, 16'd0), 32'h100, LDW, 32'h3020, 5'd8, 5'd0);
        check("lw", RD1, LDW);

        // 5: jal / jalr / no-write instructions
        step(1'b0, {6'h03, 26'h0000C02}, 32'hDEAD, 32'd0, 32'h00003000, 5'd31, 5'd0);
        check("jal_wa3", {27'd0, W_A3}, 32'd31);
        check("jal_wwd", W_WD, 32'h00003008);
        step(1'b0, rtype(5'd1, 5'd0, 5'd9, 6'h09), 32'hBEEF, 32'd0, 32'h00004000, 5'd31, 5'd9);
        check("jal_array", RD1, 32'h00003008);
        check("jalr_bypass", RD2, 32'h00004008);
        step(1'b0, rtype(5'd31, 5'd0, 5'd0, 6'h08), 32'h1, 32'd0, 32'h5000, 5'd9, 5'd0);
        check("jr_wa3", {27'd0, W_A3}, 32'd0);
        check("jalr_cv", {31'd0, commit_valid}, 32'd1);
        step(1'b0, rtype(5'd1, 5'd2, 5'd6, 6'h18), 32'h2, 32'd0, 32'h5004, 5'd6, 5'd0);
        check("mult_wa3", {27'd0, W_A3}, 32'd0);
        check("jr_cv", {31'd0, commit_valid}, 32'd0);
        step(1'b0, itype(6'h2b, 5'd1, 5'd6, 16'h4), 32'h3, 32'd0, 32'h5008, 5'd0, 5'd0);
        check("sw_wa3", {27'd0, W_A3}, 32'd0);
        step(1'b0, itype(6'h04, 5'd1, 5'd2, 16'h4), 32'h4, 32'd0, 32'h500c, 5'd0, 5'd0);
        check("sw_cv", {31'd0, commit_valid}, 32'd0);

        // 6: write to $0 dropped; reset beats a same-cycle write
        step(1'b0, rtype(5'd1, 5'd2, 5'd0, 6'h21), 32'h12345678, 32'd0, 32'h6000, 5'd0, 5'd0);
        check("r0_rd1", RD1, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0);
        check("r0_cv", {31'd0, commit_valid}, 32'd0);
        step(1'b0, itype(6'h0d, 5'd0, 5'd3, 16'h0abc), 32'h0abc, 32'd0, 32'h7000, 5'd0, 5'd0);
        step(1'b1, itype(6'h0d, 5'd0, 5'd3, 16'h0def), 32'h0def, 32'd0, 32'h7004, 5'd0, 5'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd3, 5'd0);
        check("reset_wins", RD1, 32'd0);
        check("reset_cv2", {31'd0, commit_valid}, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/w_writeback_grf.md
Name: w_writeback_grf

Overview:
- W-stage consumer of the MEM/WB pipeline register outputs.
- Decodes the W-stage instruction, then performs the writeback:
  - extends load data;
  - selects the writeback source;
  - writes the 32x32 general register file (GRF).
- Provides two D-stage read ports with internal write-to-read bypass.
- Emits a registered commit record for the testbench reference-model compare.

Parameters:
- NREG, 32, number of GRF entries; entry 0 hardwired to zero.
- DW, 32, data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IR_W  in  32  W-stage instruction word (0 = nop)
- AO_W  in  32  W-stage ALU result / memory byte address
- DR_W  in  32  raw word read from data memory
- WPC_W  in  32  W-stage instruction PC
- PC4_W  in  32  WPC_W + 4
- A1  in  5  read address 1
- A2  in  5  read address 2
- RD1  out  32  read data 1
- RD2  out  32  read data 2
- W_A3  out  5  decoded destination register this cycle (0 if no write); feeds the hazard/forwarding unit
- W_WD  out  32  selected writeback data this cycle; feeds the hazard/forwarding unit
- commit_valid  out  1  registered: a nonzero-register write committed last cycle
- commit_pc  out  32  registered PC of that write
- commit_addr  out  5  registered destination register
- commit_data  out  32  registered written value

Behaviour:
- Decode is combinational on IR_W. op = IR_W[31:26], funct = IR_W[5:0].
- Destination register:
  - op 0x00 (R-type): dest = rd, except no write for funct 0x08 (jr), 0x11 (mthi), 0x13 (mtlo), 0x18-0x1b (mult, multu, div, divu).
  - jalr (funct 0x09): writes rd.
  - jal (op 0x03): writes $31.
  - Loads (op 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu): dest = rt.
  - I-type ALU (op 0x08-0x0f): dest = rt.
  - All other opcodes (stores, branches, j): no write, W_A3 = 0.
- Writeback data source:
  - jal/jalr: PC4_W + 4, i.e. PC+8, modulo 2^32.
  - Loads: extended load data.
  - Everything else: AO_W.
- Load extension, with byte offset AO_W[1:0], little-endian:
  - lw: DR_W unchanged.
  - lb/lbu: byte DR_W[8*off+7 : 8*off], sign- or zero-extended.
  - lh/lhu: halfword at AO_W[1]; sign- or zero-extended.
  - AO_W[0] ignored for halfwords (the alignment exception is raised upstream).
- GRF write:
  - On posedge clk, when W_A3 != 0, GRF[W_A3] <= W_WD.
  - Writes to $0 are dropped; RDx for address 0 always reads 0.
- Read ports are combinational:
  - If Ax != 0 and Ax == W_A3, RDx = W_WD (same-cycle bypass).
  - Otherwise RDx = GRF[Ax].
  - Both ports may bypass simultaneously.
- Commit record is registered one cycle after the GRF write:
  - commit_valid = 1 exactly when W_A3 != 0 in the prior cycle.
  - commit_pc, commit_addr, commit_data hold the prior cycle's WPC_W, W_A3 and W_WD.
  - When no write occurs, commit_valid = 0 and the other commit fields hold their last values.
- Reset, synchronous: all GRF entries, commit_valid, commit_pc, commit_addr and commit_data are cleared to 0. Reset wins over a simultaneous write.
- W_A3 and W_WD are combinational; they read 0 while IR_W = 0.
- Writeback latency is 1 cycle: the value written at edge N is visible via the array at N+1, and via bypass during cycle N.

Decomposition:
- Shared package mips_defs:
  - opcode and funct localparams (OP_RTYPE, OP_JAL, OP_LB..OP_LHU, FN_JR, FN_JALR, FN_MULT..FN_DIVU, FN_MTHI, FN_MTLO);
  - REG_RA = 31;
  - writeback-source select encoding WB_ALU / WB_MEM / WB_PC8.
- One natural sub-module: load_ext (combinational byte/halfword extender, inputs addr[1:0], op, DR_W).

Test Plan:
1. Reset with GRF preloaded via ori sequence -> RD1/RD2 = 0 for all A1/A2 sweeps; commit_valid = 0.
2. IR_W = ori $5,$0,0x1234 (AO_W = 0x00001234), A1 = 5 -> RD1 = 0x00001234 same cycle (bypass). Next cycle: array holds it; commit_valid = 1, commit_addr = 5, commit_data = 0x00001234.
3. lb $7 with DR_W = 0x80FF7F01, AO_W[1:0] = 0..3 -> $7 = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
4. lbu of the same word at offset 3 -> $7 = 0x00000080. lh at AO_W[1] = 1 -> 0xFFFF80FF. lhu at AO_W[1] = 1 -> 0x000080FF.
5. jal with PC4_W = 0x00003004 -> $31 = 0x00003008. jalr rd = 9 -> $9 = PC+8. jr, mult and sw -> W_A3 = 0, commit_valid = 0.
6. Write to $0 (addu $0,$1,$2) -> RD1(A1 = 0) stays 0, commit_valid = 0. Reset asserted in the same cycle as a $3 write -> $3 = 0 afterwards.
